// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared state encoding for the bit-serial arithmetic sequencers
//            (serial add today; serial multiply/compare reuse the same set).
// Revision : 1.0  initial release
// ============================================================================
package serial_add_pkg;

    // Sequencer phases: waiting for operands, shifting bits, holding result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } serial_state_t;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/full_add.sv
`default_nettype none
// ============================================================================
// Module   : full_add
// Purpose  : Single-bit full adder cell (a + b + cin -> sum, cout).
// Revision : 1.0  initial release
// ============================================================================
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_half;

    assign w_half = a ^ b;
    assign sum    = w_half ^ cin;
    assign cout   = (a & b) | (cin & w_half);

endmodule : full_add
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial WIDTH-bit adder. One full_add cell is reused once per
//            clock, LSB first. Operands arrive and the result leaves on
//            valid/ready handshakes.
// Options  : SERIAL_ADD_SUB_EN - adds the 'sub' port; sub=1 computes a-b by
//            loading ~b and a carry-in of 1 (cout=1 means no borrow).
// Revision : 1.0  initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    serial_state_t    state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             start_ready_q;
    logic             res_valid_q;

    logic [WIDTH-1:0] opa_d;
    logic [WIDTH-1:0] opb_d;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_d;
    logic             w_bit_sum;
    logic             w_bit_cout;
    logic [WIDTH-1:0] w_opb_load;
    logic             w_cin_load;

    // Subtraction is a + ~b + 1, so only the B load value and carry-in differ.
`ifdef SERIAL_ADD_SUB_EN
    assign w_opb_load = sub ? ~b : b;
    assign w_cin_load = sub;
`else
    assign w_opb_load = b;
    assign w_cin_load = 1'b0;
`endif

    // The shared bit cell always looks at the current LSBs and the carry flop.
    full_add u_cell (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .sum  (w_bit_sum),
        .cout (w_bit_cout)
    );

    // Operands drain to the right; result bits enter at the MSB so that after
    // WIDTH shifts the first (LSB) sum bit has reached bit 0.
    assign opa_d = {1'b0, opa_q[WIDTH-1:1]};
    assign opb_d = {1'b0, opb_q[WIDTH-1:1]};
    assign res_d = {w_bit_sum, res_q[WIDTH-1:1]};
    assign cnt_d = cnt_q + CW'(1);

    // Sequencer FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            opa_q         <= '0;
            opb_q         <= '0;
            res_q         <= '0;
            carry_q       <= 1'b0;
            cnt_q         <= '0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid && start_ready_q) begin
                        opa_q         <= a;
                        opb_q         <= w_opb_load;
                        carry_q       <= w_cin_load;
                        cnt_q         <= '0;
                        start_ready_q <= 1'b0;
                        state_q       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    opa_q   <= opa_d;
                    opb_q   <= opb_d;
                    res_q   <= res_d;
                    carry_q <= w_bit_cout;
                    cnt_q   <= cnt_d;
                    if (cnt_q == c_LAST) begin
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Result and carry registers are left untouched on exit so
                    // sum/cout keep showing the last result while idle.
                    if (res_ready) begin
                        res_valid_q   <= 1'b0;
                        start_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_q   <= 1'b0;
                    start_ready_q <= 1'b1;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign sum         = res_q;
    assign cout        = carry_q;

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       sv8, sr8, rv8, rr8, c8;
    logic [7:0] a8, b8, sum8;
`ifdef SERIAL_ADD_SUB_EN
    logic       sub8;
    logic       sub4;
`endif
    logic       sv4, sr4, rv4, rr4, c4;
    logic [3:0] a4, b4, sum4;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] es;
        logic       ec;
        int         stall;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (sv8),
        .start_ready (sr8),
        .a           (a8),
        .b           (b8),
`ifdef SERIAL_ADD_SUB_EN
        .sub         (sub8),
`endif
        .res_valid   (rv8),
        .res_ready   (rr8),
        .sum         (sum8),
        .cout        (c8)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (sv4),
        .start_ready (sr4),
        .a           (a4),
        .b           (b4),
`ifdef SERIAL_ADD_SUB_EN
        .sub         (sub4),
`endif
        .res_valid   (rv4),
        .res_ready   (rr4),
        .sum         (sum4),
        .cout        (c4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: unsigned arithmetic straight from the operation definition.
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [7:0] diff;
        diff = x - y;
        if (s) return {(x >= y), diff};
        return {1'b0, x} + {1'b0, y};
    endfunction

    function automatic vec_t mkv(input logic [7:0] x, input logic [7:0] y, input logic s,
                                 input logic [7:0] es, input logic ec, input int stall);
        vec_t v;
        v.a = x; v.b = y; v.s = s; v.es = es; v.ec = ec; v.stall = stall;
        return v;
    endfunction

    // One full WIDTH=8 transaction with optional result backpressure.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                       input int stall, output logic [7:0] rs, output logic rc);
        int k;
        logic [8:0] exp9;
        exp9 = model8(ta, tb, ts);
        @(negedge clk);
        chk("op8_idle_start_ready", {31'd0, sr8}, 32'd1);
        a8 = ta; b8 = tb; sv8 = 1'b1; rr8 = (stall == 0);
`ifdef SERIAL_ADD_SUB_EN
        sub8 = ts;
`endif
        @(posedge clk);
        @(negedge clk);
        sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
`ifdef SERIAL_ADD_SUB_EN
        sub8 = ~ts;
`endif
        chk("op8_run_start_ready", {31'd0, sr8}, 32'd0);
        k = 0;
        while (!rv8 && k < 32) begin
            @(negedge clk);
            k++;
        end
        chk("op8_latency", k, 32'd8);
        rs = sum8; rc = c8;
        chk("op8_model_result", {23'd0, rc, rs}, {23'd0, exp9});
        for (int i = 0; i < stall; i++) begin
            sv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
            chk("bp_sum_stable", {24'd0, sum8}, {24'd0, rs});
            chk("bp_cout_stable", {31'd0, c8}, {31'd0, rc});
            chk("bp_res_valid", {31'd0, rv8}, 32'd1);
            chk("bp_start_ready", {31'd0, sr8}, 32'd0);
        end
        sv8 = 1'b0; rr8 = 1'b1;
        @(negedge clk);
        rr8 = 1'b0;
        chk("post_res_valid", {31'd0, rv8}, 32'd0);
        chk("post_start_ready", {31'd0, sr8}, 32'd1);
        chk("post_sum_hold", {23'd0, c8, sum8}, {23'd0, rc, rs});
    endtask

    // One WIDTH=4 add with a given stall; result must equal plain a+b.
    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input int stall);
        int k;
        logic [4:0] exp5;
        exp5 = {1'b0, ta} + {1'b0, tb};
        @(negedge clk);
        chk("op4_idle_start_ready", {31'd0, sr4}, 32'd1);
        a4 = ta; b4 = tb; sv4 = 1'b1; rr4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        k = 0;
        while (!rv4 && k < 16) begin
            @(negedge clk);
            k++;
        end
        chk("op4_latency", k, 32'd4);
        for (int i = 0; i < stall; i++) begin
            sv4 = 1'b1;
            @(negedge clk);
        end
        sv4 = 1'b0;
        chk("op4_result", {27'd0, c4, sum4}, {27'd0, exp5});
        rr4 = 1'b1;
        @(negedge clk);
        rr4 = 1'b0;
        chk("op4_post_res_valid", {31'd0, rv4}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rs;
        logic       rc;
        logic       rs_s;

        rst = 1'b1;
        sv8 = 1'b0; rr8 = 1'b0; a8 = '0; b8 = '0;
        sv4 = 1'b0; rr4 = 1'b0; a4 = '0; b4 = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub8 = 1'b0; sub4 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_start_ready", {31'd0, sr8}, 32'd1);
        chk("rst_res_valid", {31'd0, rv8}, 32'd0);
        chk("rst_sum_cout", {23'd0, c8, sum8}, 32'd0);
        chk("rst4_state", {25'd0, sr4, rv4, c4, sum4}, 32'h40);
        rst = 1'b0;

        // Reset asserted three cycles into RUN aborts asynchronously.
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h3C; sv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_start_ready", {31'd0, sr8}, 32'd1);
        chk("arst_res_valid", {31'd0, rv8}, 32'd0);
        chk("arst_sum_cout", {23'd0, c8, sum8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op8(8'h5A, 8'h33, 1'b0, 0, rs, rc);
        chk("after_reset_op", {23'd0, rc, rs}, {23'd0, 1'b0, 8'h8D});

        // Directed vector table.
        vecs.push_back(mkv(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 0));
        vecs.push_back(mkv(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1));
        vecs.push_back(mkv(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0));
        vecs.push_back(mkv(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 5));
        vecs.push_back(mkv(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 2));
        vecs.push_back(mkv(8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 0));
        vecs.push_back(mkv(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 3));
        vecs.push_back(mkv(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 0));
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back(mkv(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 0));
        vecs.push_back(mkv(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 2));
        vecs.push_back(mkv(8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 0));
        vecs.push_back(mkv(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1));
`endif
        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].stall, rs, rc);
            chk("table_result", {23'd0, rc, rs}, {23'd0, vecs[i].ec, vecs[i].es});
        end

        // Randomized operands and stalls against the reference model.
        for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            rs_s = 1'($urandom);
`else
            rs_s = 1'b0;
`endif
            op8(8'($urandom), 8'($urandom), rs_s, int'($urandom_range(0, 3)), rs, rc);
        end

        // WIDTH=4: every operand pair with random result stalls.
        for (int i = 0; i < 256; i++) begin
            op4(4'(i >> 4), 4'(i), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_add_ctrl
`default_nettype wire
